phase_shifter_mc: RTL and testbench
===================================

PHASE_SHIFTER_MC -- requirements
Module: phase_shifter_mc

Interface
REQ-001 Parameter N_CH, default 4: number of independent square-wave channels, 1..16.
REQ-002 Parameter CNT_W, default 17: half-period counter width.
REQ-003 Parameter HALF_MAX, default 99999: nominal terminal count, giving half-period = HALF_MAX+1 clocks.
REQ-004 Parameter FINE_STEP, default 1: fine shift, in clocks.
REQ-005 Parameter COARSE_STEP, default 50: coarse shift, in clocks; COARSE_STEP < HALF_MAX.
REQ-006 Parameter PHASE_LIM, default 1000: absolute saturation limit of the per-channel phase offset.
REQ-007 clk  in  1  sole clock, all state rises on posedge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 key_ctl  in  2  asynchronous push-buttons, active-low; bit0 = advance (left), bit1 = delay (right).
REQ-010 sw_ctl  in  1  step select: 1 = COARSE_STEP, 0 = FINE_STEP; sampled in the press-detect cycle.
REQ-011 ch_sel  in  max(1,$clog2(N_CH))  target channel for key actions and readback; values >= N_CH select nothing.
REQ-012 mod  out  N_CH  square-wave outputs, one per channel.
REQ-013 phase_off  out  signed CNT_W  accumulated offset of the ch_sel channel; 0 if ch_sel is invalid.
REQ-014 busy  out  1  shift pending on the ch_sel channel.

Function
REQ-015 Each key passes through a 2-flop synchroniser; a press is detected when the synchronised level goes 1->0, and at most one press per key is accepted until that key reads 1 again (hold lock).
REQ-016 A press-detect event occurs in the second clock after key_ctl falls, given that key_ctl meets setup time.
REQ-017 An accepted press sets pend[ch_sel], stores the direction and the step (sw_ctl), and updates phase_off of that channel by -step (left) or +step (right) in the same edge.
REQ-018 A press is discarded, with no state change and the hold lock still set, if ch_sel is invalid, if pend[ch_sel] is already 1, or if the updated offset would have magnitude > PHASE_LIM.
REQ-019 When left and right presses are detected in the same cycle, both are discarded.
REQ-020 Per channel: cnt counts up by 1 every clock; when cnt == cur_max, cnt <= 0, mod toggles, and cur_max is reloaded.
REQ-021 Reload value: HALF_MAX-step if pend with left, HALF_MAX+step if pend with right, else HALF_MAX; pend clears on that reload.
REQ-022 A press accepted in the same cycle as the channel's reload applies at the following reload; it is neither lost nor applied early.
REQ-023 The shift therefore lengthens or shortens exactly one half-period, and the waveform then resumes at nominal period.
REQ-024 Channels never interact; each channel's cnt is compared only against that channel's cur_max.
REQ-025 busy = pend[ch_sel]; busy and phase_off are combinational decodes of registered state via ch_sel.
REQ-026 Offsets are stored in two's complement with CNT_W bits, and CNT_W must hold HALF_MAX+COARSE_STEP.

Reset
REQ-027 While rst=1: cnt=0, cur_max=HALF_MAX, mod=0, pend=0, phase_off=0, synchroniser flops=1 (released), hold locks=0.
REQ-028 A reset asserted mid-operation discards pending shifts and offsets immediately; all channels restart in phase on the first clock after release.

Structure
REQ-029 Package phase_shifter_pkg holds the key index constants (KEY_LEFT=0, KEY_RIGHT=1) and the shift_dir_e enum (DIR_LEFT, DIR_RIGHT).
REQ-030 Sub-module key_press_det, instantiated once per key, holds the synchroniser, falling-edge detect and hold lock; the channel logic lives in a generate loop.

Verification
REQ-031 Test 1: N_CH=2, HALF_MAX=9, no keys -> both mod toggle every 10 clocks and stay in phase.
REQ-032 Test 2: ch_sel=0, sw_ctl=0, a single left press -> pend=1; the next half-period of mod[0] is 9 clocks, then 10; phase_off=-1; mod[1] is unchanged.
REQ-033 Test 3: ch_sel=1, sw_ctl=1, COARSE_STEP=4, right press -> one half-period of mod[1] is 14 clocks; phase_off=+4; a second press while busy=1 is ignored.
REQ-034 Test 4: PHASE_LIM=8, with offset +8 a further right press is ignored (offset stays 8) and a left press is accepted (offset becomes 7).
REQ-035 Test 5: both keys fall in the same cycle -> no pend, no offset change; holding a key for 100 clocks gives exactly one action.
REQ-036 Test 6: rst pulsed while pend=1 and offset=-3 -> after release, offset=0, busy=0, and the nominal 10-clock half-periods restart from cnt=0.

Source files
------------

// File: rtl/phase_shifter_pkg.sv
// Shared constants, direction type and reload helper for the multi-channel phase shifter.
package phase_shifter_pkg;

  localparam int KEY_LEFT  = 0;
  localparam int KEY_RIGHT = 1;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } shift_dir_e;

  // Terminal count for the next half-period: one stretched or shrunk half, else nominal.
  function automatic int unsigned reload_len(
    input int unsigned half,
    input int unsigned step,
    input logic        pend,
    input shift_dir_e  dir
  );
    if (!pend) begin
      return half;
    end else if (dir == DIR_LEFT) begin
      return half - step;
    end else begin
      return half + step;
    end
  endfunction

endpackage

// File: rtl/phase_shifter_mc_key_press_det.sv
// Push-button front end: two-flop synchroniser, falling-edge detect and hold lock.
module key_press_det (
  input  logic clk,
  input  logic rst,
  input  logic i_key_n,
  output logic o_press
);

  logic r_meta;
  logic r_sync;
  logic r_lock;
  logic w_fall;

  // The synchronised level (r_sync) is about to go 1->0 on this edge.
  assign w_fall  = r_sync & ~r_meta;
  assign o_press = w_fall & ~r_lock;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_lock <= 1'b0;
    end else begin
      r_meta <= i_key_n;
      r_sync <= r_meta;
      if (o_press) begin
        r_lock <= 1'b1;
      end else if (r_sync) begin
        r_lock <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/phase_shifter_mc.sv
// N_CH independent square-wave generators whose phase is nudged one half-period at a time
// by left/right push-button presses aimed at the channel selected by ch_sel.
module phase_shifter_mc
  import phase_shifter_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 17,
  parameter int HALF_MAX    = 99999,
  parameter int FINE_STEP   = 1,
  parameter int COARSE_STEP = 50,
  parameter int PHASE_LIM   = 1000,
  localparam int SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              key_ctl,
  input  logic                    sw_ctl,
  input  logic [SEL_W-1:0]        ch_sel,
  output logic [N_CH-1:0]         mod,
  output logic signed [CNT_W-1:0] phase_off,
  output logic                    busy
);

  localparam logic signed [CNT_W:0] LIM_POS  = (CNT_W+1)'(PHASE_LIM);
  localparam logic signed [CNT_W:0] LIM_NEG  = -LIM_POS;
  localparam logic [CNT_W-1:0]      FINE_W   = CNT_W'(FINE_STEP);
  localparam logic [CNT_W-1:0]      COARSE_W = CNT_W'(COARSE_STEP);

  logic                    w_press_l;
  logic                    w_press_r;
  logic                    w_act;
  shift_dir_e              w_dir;
  logic [CNT_W-1:0]        w_step;
  logic [N_CH-1:0]         w_hit;
  logic [N_CH-1:0]         w_pend;
  logic [N_CH-1:0]         w_accept;
  logic signed [CNT_W-1:0] w_off [N_CH];

  key_press_det u_key_left (
    .clk     (clk),
    .rst     (rst),
    .i_key_n (key_ctl[KEY_LEFT]),
    .o_press (w_press_l)
  );

  key_press_det u_key_right (
    .clk     (clk),
    .rst     (rst),
    .i_key_n (key_ctl[KEY_RIGHT]),
    .o_press (w_press_r)
  );

  // Simultaneous left and right presses cancel each other out.
  assign w_act  = w_press_l ^ w_press_r;
  assign w_dir  = w_press_r ? DIR_RIGHT : DIR_LEFT;
  assign w_step = sw_ctl ? COARSE_W : FINE_W;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [CNT_W-1:0]        r_cnt;
      logic [CNT_W-1:0]        r_cur_max;
      logic                    r_mod;
      logic                    r_pend;
      shift_dir_e              r_dir;
      logic                    r_coarse;
      logic signed [CNT_W-1:0] r_off;
      logic signed [CNT_W:0]   w_off_ext;
      logic signed [CNT_W:0]   w_step_ext;
      logic signed [CNT_W:0]   w_off_new;
      logic                    w_in_lim;
      logic                    w_reload;
      logic [CNT_W-1:0]        w_max_next;

      assign w_hit[gi]  = (ch_sel == SEL_W'(gi));
      assign w_off_ext  = {r_off[CNT_W-1], r_off};
      assign w_step_ext = {1'b0, w_step};
      assign w_off_new  = (w_dir == DIR_RIGHT) ? (w_off_ext + w_step_ext)
                                               : (w_off_ext - w_step_ext);
      assign w_in_lim   = (w_off_new <= LIM_POS) && (w_off_new >= LIM_NEG);
      assign w_accept[gi] = w_act & w_hit[gi] & ~r_pend & w_in_lim;

      assign w_reload   = (r_cnt == r_cur_max);
      assign w_max_next = CNT_W'(reload_len(HALF_MAX, r_coarse ? COARSE_STEP : FINE_STEP,
                                            r_pend, r_dir));

      assign mod[gi]    = r_mod;
      assign w_pend[gi] = r_pend;
      assign w_off[gi]  = r_off;

      // A press landing on the reload edge sets pend after the reload has used the old
      // (clear) value, so it shapes the following half-period instead.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt     <= '0;
          r_cur_max <= CNT_W'(HALF_MAX);
          r_mod     <= 1'b0;
          r_pend    <= 1'b0;
          r_dir     <= DIR_LEFT;
          r_coarse  <= 1'b0;
          r_off     <= '0;
        end else begin
          if (w_reload) begin
            r_cnt     <= '0;
            r_mod     <= ~r_mod;
            r_cur_max <= w_max_next;
            r_pend    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          if (w_accept[gi]) begin
            r_pend   <= 1'b1;
            r_dir    <= w_dir;
            r_coarse <= sw_ctl;
            r_off    <= w_off_new[CNT_W-1:0];
          end
        end
      end
    end
  endgenerate

  always_comb begin
    phase_off = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_hit[i]) begin
        phase_off = w_off[i];
      end
    end
  end

  assign busy = |(w_pend & w_hit);

endmodule

// File: tb/tb_phase_shifter_mc.sv
// Directed bench: the stimulus thread queues hand-computed half-period lengths per channel,
// a negedge monitor measures each mod toggle and checks it against the queue head.
module tb_phase_shifter_mc;

  localparam int N_CH        = 2;
  localparam int CNT_W       = 8;
  localparam int HALF_MAX    = 9;
  localparam int FINE_STEP   = 1;
  localparam int COARSE_STEP = 4;
  localparam int PHASE_LIM   = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [1:0]              key_ctl = 2'b11;
  logic                    sw_ctl = 1'b0;
  logic [0:0]              ch_sel = 1'b0;
  logic [N_CH-1:0]         mod;
  logic signed [CNT_W-1:0] phase_off;
  logic                    busy;

  int checks = 0;
  int errors = 0;
  int now    = 0;
  int exp_q0[$];
  int exp_q1[$];
  int run_len [N_CH];
  logic [N_CH-1:0] prev_mod;

  phase_shifter_mc #(
    .N_CH        (N_CH),
    .CNT_W       (CNT_W),
    .HALF_MAX    (HALF_MAX),
    .FINE_STEP   (FINE_STEP),
    .COARSE_STEP (COARSE_STEP),
    .PHASE_LIM   (PHASE_LIM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_ctl   (key_ctl),
    .sw_ctl    (sw_ctl),
    .ch_sel    (ch_sel),
    .mod       (mod),
    .phase_off (phase_off),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic push_n(input int ch, input int len, input int n);
    for (int i = 0; i < n; i++) begin
      if (ch == 0) exp_q0.push_back(len);
      else         exp_q1.push_back(len);
    end
  endtask

  task automatic check_toggle(input int ch, input int len);
    int   exp_len;
    logic got;
    got     = 1'b0;
    exp_len = 0;
    if (ch == 0 && exp_q0.size() > 0) begin
      exp_len = exp_q0.pop_front();
      got     = 1'b1;
    end else if (ch == 1 && exp_q1.size() > 0) begin
      exp_len = exp_q1.pop_front();
      got     = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL half_period_ch%0d actual toggle after %0d clocks required no toggle", ch, len);
    end else if (len != exp_len) begin
      errors++;
      $display("FAIL half_period_ch%0d actual %0d required %0d", ch, len, exp_len);
    end else begin
      $display("ok   half_period_ch%0d = %0d", ch, len);
    end
  endtask

  // Monitor: counts clocks between mod edges, sampled on the inactive edge.
  always @(negedge clk) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) run_len[c] = 0;
      prev_mod = '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        run_len[c]++;
        if (mod[c] !== prev_mod[c]) begin
          check_toggle(c, run_len[c]);
          run_len[c]  = 0;
          prev_mod[c] = mod[c];
        end
      end
    end
  end

  // Advance to 1 time unit after posedge number e since the last reset release.
  task automatic at(input int e);
    repeat (e - now) @(posedge clk);
    now = e;
    #1;
  endtask

  // mask bit0 = left, bit1 = right; the press is accepted on edge a.
  task automatic press(input logic [1:0] mask, input logic sel, input logic sw, input int a);
    at(a - 2);
    ch_sel  = sel;
    sw_ctl  = sw;
    key_ctl = ~mask;
    at(a);
    key_ctl = 2'b11;
  endtask

  task automatic chk_out(input string name, input int exp_busy, input int exp_off);
    chk({name, "_busy"}, int'(busy), exp_busy);
    chk({name, "_phase_off"}, int'($signed(phase_off)), exp_off);
  endtask

  task automatic release_rst();
    @(negedge clk);
    #1;
    rst = 1'b0;
    now = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mod", int'(mod), 0);
    chk_out("reset", 0, 0);

    // ch0: nominal x5, -1 fine, nominal, coarse left applied one reload late, nominal, +1 fine.
    push_n(0, 10, 5); push_n(0, 9, 1); push_n(0, 10, 8); push_n(0, 6, 1);
    push_n(0, 10, 10); push_n(0, 11, 1);
    // ch1: nominal x7, +4, nominal, +4, nominal, -1, nominal.
    push_n(1, 10, 7); push_n(1, 14, 1); push_n(1, 10, 1); push_n(1, 14, 1);
    push_n(1, 10, 1); push_n(1, 9, 1); push_n(1, 10, 13);
    release_rst();

    // Test 1: free-running, both channels in phase.
    at(35);
    chk("t1_mod_in_phase", int'(mod), 3);
    chk_out("t1", 0, 0);

    // Test 2: fine left press on ch0.
    press(2'b01, 1'b0, 1'b0, 42);
    at(43);
    chk_out("t2_pending", 1, -1);
    at(51);
    chk_out("t2_applied", 0, -1);

    // Test 3: coarse right on ch1, second press while busy is ignored.
    press(2'b10, 1'b1, 1'b1, 62);
    at(63);
    chk_out("t3_pending", 1, 4);
    press(2'b10, 1'b1, 1'b1, 66);
    at(67);
    chk_out("t3_busy_ignored", 1, 4);

    // Test 4: reach +8, then +1 would exceed the limit, -1 is allowed.
    press(2'b10, 1'b1, 1'b1, 88);
    at(89);
    chk_out("t4_at_limit", 1, 8);
    press(2'b10, 1'b1, 1'b0, 100);
    at(101);
    chk_out("t4_over_limit", 0, 8);
    press(2'b01, 1'b1, 1'b0, 110);
    at(111);
    chk_out("t4_back_in", 1, 7);

    // Test 5: both keys together, then one long hold landing on ch0's reload edge.
    press(2'b11, 1'b0, 1'b0, 122);
    at(123);
    chk_out("t5_both_keys", 0, -1);
    at(127);
    ch_sel  = 1'b0;
    sw_ctl  = 1'b1;
    key_ctl = 2'b10;
    at(130);
    chk_out("t5_hold_start", 1, -5);
    at(200);
    chk_out("t5_hold_once", 0, -5);
    at(229);
    key_ctl = 2'b11;

    // Test 6: build offset -3 with a shift pending, then reset.
    press(2'b10, 1'b0, 1'b0, 240);
    at(241);
    chk_out("t6_step1", 1, -4);
    press(2'b10, 1'b0, 1'b0, 260);
    at(261);
    chk_out("t6_pending", 1, -3);
    at(262);
    rst = 1'b1;
    #1;
    chk("t6_rst_mod", int'(mod), 0);
    chk_out("t6_in_reset", 0, 0);
    chk("t6_ch0_all_seen", exp_q0.size(), 0);
    chk("t6_ch1_all_seen", exp_q1.size(), 0);
    push_n(0, 10, 3);
    push_n(1, 10, 3);
    repeat (2) @(posedge clk);
    release_rst();
    at(1);
    chk_out("t6_after_release", 0, 0);
    at(35);
    chk("t6_mod_in_phase", int'(mod), 3);
    chk("t6_ch0_drained", exp_q0.size(), 0);
    chk("t6_ch1_drained", exp_q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
